// File: rtl/axis_pkt_checker_if.sv
// AXI-Stream bundle feeding the packet checker; the checker uses the slave modport.
interface axis_pkt_checker_if #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH/8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pkt_checker.sv
// Receive-side checker for generator test traffic: one header beat, then an incrementing 64-bit payload.
// Define PKT_CHECKER_FLOW_STATS_EN to build the per-flow packet counters (flow_pkt_count reads 0 otherwise).
module axis_pkt_checker #(
   parameter int DATA_WIDTH    = 512,
   parameter int KEEP_WIDTH    = DATA_WIDTH/8,
   parameter int FLOW_ID_WIDTH = 3,
   parameter int MAX_BEATS     = 32,
   parameter int CNT_WIDTH     = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic                     clear,
   axis_pkt_checker_if.slave        s_axis,
   output logic                     pkt_done,
   output logic                     pkt_ok,
   output logic [FLOW_ID_WIDTH-1:0] pkt_flow,
   output logic [5:0]               pkt_beats,
   output logic [CNT_WIDTH-1:0]     pkt_count,
   output logic [CNT_WIDTH-1:0]     byte_count,
   output logic [CNT_WIDTH-1:0]     err_count,
   output logic [3:0]               err_flags,
   input  logic [FLOW_ID_WIDTH-1:0] flow_sel,
   output logic [CNT_WIDTH-1:0]     flow_pkt_count
);
   // state   | meaning
   // S_HDR   | waiting for the header beat of the next packet
   // S_FIRST | payload beat 1; latches the sequence base, no data check
   // S_PAY   | payload beats 2..n; data checked against base + beat index
   // S_DROP  | packet already bad; swallow beats until tlast
   typedef enum logic [1:0] {S_HDR, S_FIRST, S_PAY, S_DROP} state_t;

   localparam int ERR_HDR  = 0;
   localparam int ERR_LEN  = 1;
   localparam int ERR_KEEP = 2;
   localparam int ERR_DATA = 3;
   localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] BEAT_BYTES = CNT_WIDTH'(KEEP_WIDTH);

   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [CNT_WIDTH-1:0] b);
      logic [CNT_WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
   endfunction

   state_t                   state_q, state_d;
   logic [5:0]               beat_idx_q, beat_idx_d;
   logic [5:0]               left_q, left_d;
   logic [FLOW_ID_WIDTH-1:0] flow_q, flow_d;
   logic [63:0]              base_q, base_d;
   logic [3:0]               perr_q, perr_d;
   logic                     pkt_done_q, pkt_done_d;
   logic                     pkt_ok_q, pkt_ok_d;
   logic [FLOW_ID_WIDTH-1:0] pkt_flow_q, pkt_flow_d;
   logic [5:0]               pkt_beats_q, pkt_beats_d;
   logic [CNT_WIDTH-1:0]     pkt_count_q, pkt_count_d;
   logic [CNT_WIDTH-1:0]     byte_count_q, byte_count_d;
   logic [CNT_WIDTH-1:0]     err_count_q, err_count_d;
   logic [3:0]               err_flags_q, err_flags_d;

   logic                     accept;
   logic [15:0]              hdr_len;
   logic [16:0]              hdr_exp;
   logic                     hdr_bad;
   logic [FLOW_ID_WIDTH-1:0] hdr_flow;
   logic                     keep_bad;
   logic [63:0]              pay_word;
   logic [63:0]              exp_word;
   logic [5:0]               idx_inc;
   logic [3:0]               pkt_err;
   logic                     done;
   logic [FLOW_ID_WIDTH-1:0] done_flow;
   logic                     unused_tdata;

   assign s_axis.tready = enable;
   assign accept        = s_axis.tvalid & enable;
   assign hdr_len       = {s_axis.tdata[135:128], s_axis.tdata[143:136]};
   // 14 bytes of Ethernet header plus round-up to whole 64-byte beats
   assign hdr_exp       = (17'(hdr_len) + 17'd77) >> 6;
   assign hdr_bad       = (hdr_exp == 17'd0) || (hdr_exp > 17'(MAX_BEATS));
   assign hdr_flow      = s_axis.tdata[280 +: FLOW_ID_WIDTH];
   assign keep_bad      = (s_axis.tkeep != {KEEP_WIDTH{1'b1}});
   assign pay_word      = s_axis.tdata[63:0];
   assign exp_word      = base_q + 64'(beat_idx_q);
   assign idx_inc       = (beat_idx_q == 6'h3f) ? beat_idx_q : beat_idx_q + 6'd1;
   assign unused_tdata  = ^{s_axis.tdata[DATA_WIDTH-1:280+FLOW_ID_WIDTH],
                            s_axis.tdata[279:144], s_axis.tdata[127:64]};

   always_comb begin
      state_d    = state_q;
      beat_idx_d = beat_idx_q;
      left_d     = left_q;
      flow_d     = flow_q;
      base_d     = base_q;
      pkt_err    = perr_q;
      done       = 1'b0;
      done_flow  = flow_q;
      if (accept) begin
         case (state_q)
            S_HDR: begin
               flow_d     = hdr_flow;
               done_flow  = hdr_flow;
               left_d     = hdr_exp[5:0] - 6'd1;
               beat_idx_d = 6'd1;
               pkt_err    = 4'b0000;
               pkt_err[ERR_HDR]  = hdr_bad;
               pkt_err[ERR_KEEP] = keep_bad;
               if (s_axis.tlast) begin
                  pkt_err[ERR_LEN] = (hdr_exp != 17'd1);
                  done = 1'b1;
               end else if (hdr_bad) begin
                  state_d = S_DROP;
               end else if (hdr_exp == 17'd1) begin
                  pkt_err[ERR_LEN] = 1'b1;
                  state_d = S_DROP;
               end else begin
                  state_d = S_FIRST;
               end
            end
            S_FIRST, S_PAY: begin
               beat_idx_d = idx_inc;
               left_d     = left_q - 6'd1;
               if (keep_bad) pkt_err[ERR_KEEP] = 1'b1;
               if (state_q == S_FIRST) base_d = pay_word - 64'd1;
               else if (pay_word != exp_word) pkt_err[ERR_DATA] = 1'b1;
               // left_q == 1 marks the beat that must carry tlast
               if (s_axis.tlast) begin
                  if (left_q != 6'd1) pkt_err[ERR_LEN] = 1'b1;
                  done = 1'b1;
               end else if (left_q == 6'd1) begin
                  pkt_err[ERR_LEN] = 1'b1;
                  state_d = S_DROP;
               end else begin
                  state_d = S_PAY;
               end
            end
            S_DROP: begin
               beat_idx_d = idx_inc;
               if (s_axis.tlast) done = 1'b1;
            end
            default: state_d = S_HDR;
         endcase
      end
      if (done) state_d = S_HDR;
      perr_d      = done ? 4'b0000 : pkt_err;
      pkt_done_d  = done;
      pkt_ok_d    = done ? ~|pkt_err : pkt_ok_q;
      pkt_flow_d  = done ? done_flow : pkt_flow_q;
      pkt_beats_d = done ? beat_idx_d : pkt_beats_q;

      pkt_count_d  = clear ? '0 : pkt_count_q;
      byte_count_d = clear ? '0 : byte_count_q;
      err_count_d  = clear ? '0 : err_count_q;
      err_flags_d  = clear ? 4'b0000 : err_flags_q;
      if (accept) byte_count_d = sat_add(byte_count_d, BEAT_BYTES);
      if (done) begin
         pkt_count_d = sat_add(pkt_count_d, ONE);
         err_flags_d = err_flags_d | pkt_err;
         if (|pkt_err) err_count_d = sat_add(err_count_d, ONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_HDR;
         beat_idx_q   <= '0;
         left_q       <= '0;
         flow_q       <= '0;
         base_q       <= '0;
         perr_q       <= '0;
         pkt_done_q   <= 1'b0;
         pkt_ok_q     <= 1'b0;
         pkt_flow_q   <= '0;
         pkt_beats_q  <= '0;
         pkt_count_q  <= '0;
         byte_count_q <= '0;
         err_count_q  <= '0;
         err_flags_q  <= '0;
      end else begin
         state_q      <= state_d;
         beat_idx_q   <= beat_idx_d;
         left_q       <= left_d;
         flow_q       <= flow_d;
         base_q       <= base_d;
         perr_q       <= perr_d;
         pkt_done_q   <= pkt_done_d;
         pkt_ok_q     <= pkt_ok_d;
         pkt_flow_q   <= pkt_flow_d;
         pkt_beats_q  <= pkt_beats_d;
         pkt_count_q  <= pkt_count_d;
         byte_count_q <= byte_count_d;
         err_count_q  <= err_count_d;
         err_flags_q  <= err_flags_d;
      end
   end

   assign pkt_done   = pkt_done_q;
   assign pkt_ok     = pkt_ok_q;
   assign pkt_flow   = pkt_flow_q;
   assign pkt_beats  = pkt_beats_q;
   assign pkt_count  = pkt_count_q;
   assign byte_count = byte_count_q;
   assign err_count  = err_count_q;
   assign err_flags  = err_flags_q;

`ifdef PKT_CHECKER_FLOW_STATS_EN
   localparam int NUM_FLOWS = 1 << FLOW_ID_WIDTH;
   logic [CNT_WIDTH-1:0] flow_cnt_q [NUM_FLOWS];
   logic [CNT_WIDTH-1:0] flow_cnt_d [NUM_FLOWS];
   logic [CNT_WIDTH-1:0] flow_pkt_count_q, flow_pkt_count_d;

   always_comb begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
         flow_cnt_d[i] = clear ? '0 : flow_cnt_q[i];
         if (done && (done_flow == FLOW_ID_WIDTH'(i))) flow_cnt_d[i] = sat_add(flow_cnt_d[i], ONE);
      end
      flow_pkt_count_d = flow_cnt_q[flow_sel];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_FLOWS; i++) flow_cnt_q[i] <= '0;
         flow_pkt_count_q <= '0;
      end else begin
         for (int i = 0; i < NUM_FLOWS; i++) flow_cnt_q[i] <= flow_cnt_d[i];
         flow_pkt_count_q <= flow_pkt_count_d;
      end
   end

   assign flow_pkt_count = flow_pkt_count_q;
`else
   logic unused_flow_sel;
   assign unused_flow_sel = ^flow_sel;
   assign flow_pkt_count  = '0;
`endif
endmodule

// File: tb/tb_axis_pkt_checker.sv
// Bench for axis_pkt_checker: packet table plus hand-written reset/clear/flow-stat sequences.
module tb_axis_pkt_checker;
   localparam int DW = 512;
   localparam int KW = 64;
   localparam int FW = 3;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          clear = 1'b0;
   logic [FW-1:0] flow_sel = '0;
   logic          pkt_done, pkt_ok;
   logic [FW-1:0] pkt_flow;
   logic [5:0]    pkt_beats;
   logic [CW-1:0] pkt_count, byte_count, err_count, flow_pkt_count;
   logic [3:0]    err_flags;

   axis_pkt_checker_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s_axis();

   axis_pkt_checker #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .FLOW_ID_WIDTH(FW),
                      .MAX_BEATS(32), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .s_axis(s_axis),
      .pkt_done(pkt_done), .pkt_ok(pkt_ok), .pkt_flow(pkt_flow), .pkt_beats(pkt_beats),
      .pkt_count(pkt_count), .byte_count(byte_count), .err_count(err_count),
      .err_flags(err_flags), .flow_sel(flow_sel), .flow_pkt_count(flow_pkt_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          ok;
      logic [FW-1:0] flow;
      logic [5:0]    beats;
   } exp_t;

   typedef struct {
      int     len;
      int     flow;
      int     nbeats;
      longint base;
      int     data_err_k;
      int     keep_err_k;
      bit     stall;
      bit     pre_clear;
      logic   exp_ok;
      int     exp_beats;
      logic [3:0] exp_flags;
   } vec_t;

   exp_t   sb_q[$];
   exp_t   mon_e;
   vec_t   vecs[10];
   int     n_checks = 0;
   int     n_fail = 0;
   longint exp_pkt, exp_bytes, exp_err;
   logic [3:0] exp_flags;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (pkt_done === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pkt_done: got pkt_done=1 expected no completion");
         end else begin
            mon_e = sb_q.pop_front();
            chk("pkt_ok", 64'(pkt_ok), 64'(mon_e.ok));
            chk("pkt_flow", 64'(pkt_flow), 64'(mon_e.flow));
            chk("pkt_beats", 64'(pkt_beats), 64'(mon_e.beats));
         end
      end
   end

   task automatic drive_beat(input int k, input int len, input int flow, input longint base,
                             input int de, input int ke, input bit last);
      logic [DW-1:0] d;
      d = '0;
      if (k == 0) begin
         d[135:128] = len[15:8];
         d[143:136] = len[7:0];
         d[287:280] = flow[7:0];
      end else begin
         d[63:0] = base + longint'(k) + ((k == de) ? 64'd1 : 64'd0);
      end
      s_axis.tdata  = d;
      s_axis.tkeep  = (k == ke) ? '0 : '1;
      s_axis.tvalid = 1'b1;
      s_axis.tlast  = last;
   endtask

   task automatic send_pkt(input int len, input int flow, input int nbeats, input longint base,
                           input int de, input int ke, input bit stall, input bit with_last);
      for (int k = 0; k < nbeats; k++) begin
         @(negedge clk);
         drive_beat(k, len, flow, base, de, ke, with_last && (k == nbeats - 1));
         if (stall && k == 2) begin
            enable = 1'b0;
            repeat (3) @(negedge clk);
            chk("tready_stalled", 64'(s_axis.tready), 64'd0);
            enable = 1'b1;
         end
      end
      @(negedge clk);
      s_axis.tvalid = 1'b0;
      s_axis.tlast  = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL pkt_done_timeout: got %0d pending expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic push_exp(input logic ok, input int flow, input int beats);
      exp_t e;
      e.ok = ok;
      e.flow = FW'(flow);
      e.beats = 6'(beats);
      sb_q.push_back(e);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic chk_counters(input string tag);
      chk({tag, "_pkt_count"}, 64'(pkt_count), exp_pkt);
      chk({tag, "_byte_count"}, 64'(byte_count), exp_bytes);
      chk({tag, "_err_count"}, 64'(err_count), exp_err);
      chk({tag, "_err_flags"}, 64'(err_flags), 64'(exp_flags));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of test expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //          len   fl nb base  de  ke  st clr ok beats flags
      vecs[0] = '{50,   5, 1,  0,   -1, -1, 0, 0,  1, 1,  4'b0000};
      vecs[1] = '{2034, 2, 32, 7,   -1, -1, 1, 1,  1, 32, 4'b0000};
      vecs[2] = '{2034, 3, 10, 100, -1, -1, 0, 1,  0, 10, 4'b0010};
      vecs[3] = '{50,   6, 1,  0,   -1, -1, 0, 0,  1, 1,  4'b0000};
      vecs[4] = '{498,  4, 8,  1000, 4,  6, 0, 1,  0, 8,  4'b1100};
      vecs[5] = '{3000, 1, 3,  0,   -1, -1, 0, 0,  0, 3,  4'b0001};
      vecs[6] = '{200,  2, 1,  0,   -1, -1, 0, 0,  0, 1,  4'b0010};
      vecs[7] = '{100,  7, 4,  50,  -1, -1, 0, 0,  0, 4,  4'b0010};
      vecs[8] = '{50,   0, 1,  0,   -1,  0, 0, 0,  0, 1,  4'b0100};
      vecs[9] = '{100,  3, 2,  5,   -1, -1, 0, 0,  1, 2,  4'b0000};

      s_axis.tdata  = '0;
      s_axis.tkeep  = '0;
      s_axis.tvalid = 1'b0;
      s_axis.tlast  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_pkt_done", 64'(pkt_done), 64'd0);
      chk("rst_pkt_ok", 64'(pkt_ok), 64'd0);
      chk("rst_pkt_flow", 64'(pkt_flow), 64'd0);
      chk("rst_pkt_beats", 64'(pkt_beats), 64'd0);
      chk("rst_pkt_count", 64'(pkt_count), 64'd0);
      chk("rst_byte_count", 64'(byte_count), 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
      chk("rst_err_flags", 64'(err_flags), 64'd0);
      chk("rst_flow_pkt_count", 64'(flow_pkt_count), 64'd0);
      chk("rst_tready", 64'(s_axis.tready), 64'd0);
      rst_n  = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      chk("tready_enabled", 64'(s_axis.tready), 64'd1);

      exp_pkt = 0; exp_bytes = 0; exp_err = 0; exp_flags = 4'b0000;
      for (int v = 0; v < 10; v++) begin
         if (vecs[v].pre_clear) begin
            pulse_clear();
            exp_pkt = 0; exp_bytes = 0; exp_err = 0; exp_flags = 4'b0000;
         end
         push_exp(vecs[v].exp_ok, vecs[v].flow, vecs[v].exp_beats);
         send_pkt(vecs[v].len, vecs[v].flow, vecs[v].nbeats, vecs[v].base,
                  vecs[v].data_err_k, vecs[v].keep_err_k, vecs[v].stall, 1'b1);
         wait_done();
         @(negedge clk);
         exp_pkt++;
         exp_bytes += 64 * vecs[v].nbeats;
         if (!vecs[v].exp_ok) exp_err++;
         exp_flags |= vecs[v].exp_flags;
         chk_counters($sformatf("vec%0d", v));
      end

      // clear on the same edge as a completing good packet
      @(negedge clk);
      push_exp(1'b1, 1, 1);
      drive_beat(0, 50, 1, 0, -1, -1, 1'b1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      s_axis.tvalid = 1'b0;
      s_axis.tlast  = 1'b0;
      wait_done();
      @(negedge clk);
      exp_pkt = 1; exp_bytes = 64; exp_err = 0; exp_flags = 4'b0000;
      chk_counters("clr_inc");

      // reset in the middle of a 32-beat packet
      send_pkt(2034, 2, 5, 7, -1, -1, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      exp_pkt = 0; exp_bytes = 0; exp_err = 0; exp_flags = 4'b0000;
      chk_counters("mid_rst");
      chk("mid_rst_pkt_done", 64'(pkt_done), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push_exp(1'b1, 6, 1);
      send_pkt(50, 6, 1, 0, -1, -1, 1'b0, 1'b1);
      wait_done();
      @(negedge clk);
      exp_pkt = 1; exp_bytes = 64;
      chk_counters("post_rst");

`ifdef PKT_CHECKER_FLOW_STATS_EN
      pulse_clear();
      begin
         int flows[6];
         flows = '{5, 5, 6, 7, 7, 7};
         for (int i = 0; i < 6; i++) begin
            push_exp(1'b1, flows[i], 1);
            send_pkt(50, flows[i], 1, 0, -1, -1, 1'b0, 1'b1);
         end
      end
      wait_done();
      flow_sel = 3'd7;
      @(negedge clk);
      chk("flow7_count", 64'(flow_pkt_count), 64'd3);
      flow_sel = 3'd5;
      @(negedge clk);
      chk("flow5_count", 64'(flow_pkt_count), 64'd2);
      flow_sel = 3'd6;
      @(negedge clk);
      chk("flow6_count", 64'(flow_pkt_count), 64'd1);
      flow_sel = 3'd7;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
      chk("flow7_after_clear", 64'(flow_pkt_count), 64'd0);
`else
      flow_sel = 3'd6;
      @(negedge clk);
      @(negedge clk);
      chk("flow_stats_off", 64'(flow_pkt_count), 64'd0);
`endif

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/axis_pkt_checker.md
Name: axis_pkt_checker

Overview:
- Synthesizable receive-side checker for the 512-bit AXI-Stream test traffic the packet generator emits: one header beat carrying the UDP/IPv4 length and flow id, followed by an incrementing 64-bit payload pattern.
- Sits on the PANIC pipeline output (the m_rx_axis port), in place of or alongside the DMA sink.
- Validates packet framing, tkeep, beat count against the header length, and payload sequence.
- Reports per-packet results and aggregate counters for on-chip throughput and error measurement.

Parameters:
- DATA_WIDTH, 512, AXIS data width in bits; must be 512 because header byte offsets are fixed.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- FLOW_ID_WIDTH, 3, flow id bits taken from header byte 35 (flows 0..7).
- MAX_BEATS, 32, largest legal packet in beats (2048B).
- CNT_WIDTH, 32, width of every statistics counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- enable  in  1  drives s_axis_tready; low back-pressures the upstream.
- clear  in  1  synchronous one-cycle clear of all counters and sticky flags.
- s_axis_tdata  in  DATA_WIDTH  stream data.
- s_axis_tkeep  in  KEEP_WIDTH  byte enables.
- s_axis_tvalid  in  1  valid.
- s_axis_tready  out  1  ready; equals enable combinationally.
- s_axis_tlast  in  1  last beat of packet.
- pkt_done  out  1  one-cycle pulse, one cycle after the accepted tlast beat.
- pkt_ok  out  1  qualifies pkt_done; 1 = no error in this packet.
- pkt_flow  out  FLOW_ID_WIDTH  flow id of the completed packet.
- pkt_beats  out  6  accepted beat count of the completed packet.
- pkt_count  out  CNT_WIDTH  packets completed.
- byte_count  out  CNT_WIDTH  accepted beats times KEEP_WIDTH.
- err_count  out  CNT_WIDTH  packets completed with pkt_ok=0.
- err_flags  out  4  sticky flags: [0] HDR, [1] LEN, [2] KEEP, [3] DATA.
- flow_sel  in  FLOW_ID_WIDTH  per-flow statistics read index.
- flow_pkt_count  out  CNT_WIDTH  packets completed for flow_sel.

Behaviour:
- Reset values: all outputs 0; FSM in HDR; all counters 0.
- Beat accepted = s_axis_tvalid & s_axis_tready.
- Header beat field extraction:
  - len = {byte16, byte17}.
  - exp_beats = (len + 14 + 63) >> 6.
  - flow = byte35[FLOW_ID_WIDTH-1:0].
  - ERR_HDR if exp_beats == 0 or exp_beats > MAX_BEATS.
- HDR state:
  - On an accepted beat, latch flow and exp_beats, set beat_idx = 1, and evaluate HDR and KEEP errors.
  - If tlast: packet completes; ERR_LEN if exp_beats != 1. Stay in HDR.
  - Else go to FIRST.
- FIRST state (payload beat 1): latch base = tdata[63:0] - 1; no DATA check on this beat.
- PAY state, beat k: ERR_DATA if tdata[63:0] != base + k (64-bit wrap-around).
- Every non-header beat:
  - KEEP check requires all ones on every beat, including the last.
  - beat_idx increments.
  - ERR_LEN if tlast arrives with beat_idx+1 != exp_beats.
  - ERR_LEN if beat_idx+1 == exp_beats without tlast; FSM then goes to DROP.
- DROP state: accepts beats without checking until tlast, then completes the packet (ok=0) and returns to HDR.
- A header error also forces DROP after the header beat unless tlast.
- Errors within a packet OR into a per-packet bad bit, which is cleared on completion. err_flags are sticky and set from the per-packet bits.
- Completion: registered pkt_done=1, pkt_ok=!bad, pkt_flow, pkt_beats.
  - pkt_count increments.
  - err_count increments once per bad packet, not once per error.
- Counters saturate at all-ones.
- byte_count adds KEEP_WIDTH per accepted beat, including dropped beats.
- clear coinciding with an increment: result is the increment applied to 0 (value 1 or KEEP_WIDTH). clear does not disturb the FSM or an in-flight packet.
- enable low: no beats accepted and no state change; a packet may be stalled mid-way indefinitely.
- rst_n low mid-packet: immediate return to HDR, partial packet discarded, no pkt_done.

Optional Feature:
- PKT_CHECKER_FLOW_STATS_EN defined: instantiates 2^FLOW_ID_WIDTH saturating per-flow packet counters.
  - The counter selected by pkt_flow increments on pkt_done, for good and bad packets alike.
  - clear zeroes all of them.
  - flow_pkt_count is a registered read of counter[flow_sel], one cycle of latency.
- Undefined: no per-flow storage; flow_pkt_count is tied to 0.

Test Plan:
- 1-beat packet, len=50, flow 5, tkeep all ones, tlast → pkt_done, ok=1, flow=5, beats=1; pkt_count=1; byte_count=64.
- 32-beat packet, len=2034, payload beat k = 7+k (k=1..31), enable=1 → ok=1, beats=32, byte_count=2048, err_flags=0.
- 32-beat header with tlast on beat 10 → ok=0, beats=10, err_flags[1]=1, err_count=1; next good 1-beat packet → ok=1.
- 8-beat packet (len=498) with beat 4 data +1 and beat 6 tkeep=0 → ok=0, err_flags=4'b1100, err_count=1 (single increment).
- rst_n pulsed low mid-way through a 32-beat packet → no pkt_done; counters 0; the following 1-beat packet completes with ok=1.
- With PKT_CHECKER_FLOW_STATS_EN: packets on flows 5,5,6,7,7,7 then flow_sel=7 → flow_pkt_count=3 one cycle later; clear → 0.
